// File: rtl/fan_tach_meter.sv
// Fan tachometer meter: counts synchronised tach rising edges over a fixed gate window.
// Optional tach glitch filter is enabled by defining TACH_DEBOUNCE_EN.
module fan_tach_meter #(
  parameter int GATE_CYCLES     = 10000,
  parameter int COUNT_W         = 16,
  parameter int STALL_CYCLES    = 20000,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               tach_in,
  output logic [COUNT_W-1:0] freq_count,
  output logic               freq_valid,
  output logic               overflow,
  output logic               stalled
);

  localparam int GATE_W  = $clog2(GATE_CYCLES);
  localparam int STALL_W = $clog2(STALL_CYCLES);
  localparam logic [GATE_W-1:0]  GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX  = '1;

  if (GATE_CYCLES < 2 || STALL_CYCLES < 2 || DEBOUNCE_CYCLES < 1 || COUNT_W < 1) begin : g_param_check
    $error("fan_tach_meter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LATCH   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic sync1_q, sync2_q, sync3_q;
  logic level;
  logic tach_edge;

  logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
  logic [COUNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic               sticky_q, sticky_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               stalled_q, stalled_d;
  logic [COUNT_W-1:0] freq_count_q, freq_count_d;
  logic               overflow_q, overflow_d;
  logic               freq_valid_q, freq_valid_d;

  // sync1/sync2 form the metastability synchroniser; sync3 delays the edge-detect level
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= tach_in;
      sync2_q <= sync1_q;
      sync3_q <= level;
    end
  end

`ifdef TACH_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic             filt_q, filt_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  // Filtered level follows sync2 only after it has disagreed for DEBOUNCE_CYCLES cycles in a row
  always_comb begin
    filt_d    = filt_q;
    deb_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        filt_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      filt_q    <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      filt_q    <= filt_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  assign tach_edge = level & ~sync3_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Dropping enable aborts the window even on its last cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = MEASURE;
      MEASURE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (gate_cnt_q == GATE_LAST) begin
          state_d = LATCH;
        end
      end
      LATCH:   state_d = enable ? MEASURE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Results load on entry to LATCH so freq_count is already new while freq_valid is high
  always_comb begin
    gate_cnt_d   = '0;
    pulse_cnt_d  = '0;
    sticky_d     = 1'b0;
    stall_cnt_d  = '0;
    stalled_d    = 1'b0;
    freq_count_d = freq_count_q;
    overflow_d   = overflow_q;
    freq_valid_d = 1'b0;

    unique case (state_q)
      MEASURE: begin
        gate_cnt_d  = gate_cnt_q + 1'b1;
        pulse_cnt_d = pulse_cnt_q;
        sticky_d    = sticky_q;
        if (tach_edge) begin
          if (pulse_cnt_q == COUNT_MAX) begin
            sticky_d = 1'b1;
          end else begin
            pulse_cnt_d = pulse_cnt_q + 1'b1;
          end
        end
        if (state_d == LATCH) begin
          freq_count_d = pulse_cnt_d;
          overflow_d   = sticky_d;
          freq_valid_d = 1'b1;
        end
      end
      LATCH: begin
        pulse_cnt_d = COUNT_W'(tach_edge);
      end
      default: ;
    endcase

    // An edge always beats the stall threshold in the same cycle
    if (state_q != IDLE) begin
      if (tach_edge) begin
        stall_cnt_d = '0;
        stalled_d   = 1'b0;
      end else begin
        stall_cnt_d = (stall_cnt_q == STALL_LAST) ? stall_cnt_q : stall_cnt_q + 1'b1;
        stalled_d   = stalled_q | (stall_cnt_d == STALL_LAST);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt_q   <= '0;
      pulse_cnt_q  <= '0;
      sticky_q     <= 1'b0;
      stall_cnt_q  <= '0;
      stalled_q    <= 1'b0;
      freq_count_q <= '0;
      overflow_q   <= 1'b0;
      freq_valid_q <= 1'b0;
    end else begin
      gate_cnt_q   <= gate_cnt_d;
      pulse_cnt_q  <= pulse_cnt_d;
      sticky_q     <= sticky_d;
      stall_cnt_q  <= stall_cnt_d;
      stalled_q    <= stalled_d;
      freq_count_q <= freq_count_d;
      overflow_q   <= overflow_d;
      freq_valid_q <= freq_valid_d;
    end
  end

  assign freq_count = freq_count_q;
  assign freq_valid = freq_valid_q;
  assign overflow   = overflow_q;
  assign stalled    = stalled_q;

endmodule

// File: tb/tb_fan_tach_meter.sv
// Directed bench for fan_tach_meter: per-window vector table plus abort, stall and reset sequences.
// Expected values also cover the TACH_DEBOUNCE_EN build.
module tb_fan_tach_meter;

  localparam int G   = 100;
  localparam int WIN = G + 1;
  localparam int NV  = 10;
`ifdef TACH_DEBOUNCE_EN
  localparam int L = 2 + 4;
`else
  localparam int L = 2;
`endif

  typedef struct {
    int period;
    int width;
    int first;
    int tail;
    int exp_cnt;
    int exp_nar;
    int exp_ovf;
  } vec_t;

  logic       clk_in  = 1'b0;
  logic       rst_n   = 1'b0;
  logic       enable  = 1'b0;
  logic       tach_in = 1'b0;
  logic [7:0] freq_count;
  logic       freq_valid, overflow, stalled;
  logic [3:0] nar_count;
  logic       nar_valid, nar_ovf, nar_stalled;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  vec_t vecs [NV];

  fan_tach_meter #(.GATE_CYCLES(G), .COUNT_W(8), .STALL_CYCLES(50), .DEBOUNCE_CYCLES(4)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .tach_in(tach_in),
    .freq_count(freq_count), .freq_valid(freq_valid), .overflow(overflow), .stalled(stalled)
  );

  fan_tach_meter #(.GATE_CYCLES(G), .COUNT_W(4), .STALL_CYCLES(50), .DEBOUNCE_CYCLES(4)) dut_nar (
    .clk_in(clk_in), .rst_n(rst_n), .enable(enable), .tach_in(tach_in),
    .freq_count(nar_count), .freq_valid(nar_valid), .overflow(nar_ovf), .stalled(nar_stalled)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit pat(input vec_t v, input int i);
    if (v.tail != 0 && i == 100) return 1'b1;
    if (v.period == 0 || i < v.first || i >= 100) return 1'b0;
    return ((i - v.first) % v.period) < v.width;
  endfunction

  initial begin
    int n0, vend, m, r0, d, k, i, w;
    bit lvl, exp_v;

    vecs[0] = '{0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{10, 5, 0, 0, 10, 10, 0};
    vecs[2] = '{10, 5, 1, 0, 10, 10, 0};
`ifdef TACH_DEBOUNCE_EN
    vecs[3] = '{4, 2, 0, 0, 0, 0, 0};
    vecs[5] = '{10, 2, 0, 0, 0, 0, 0};
`else
    vecs[3] = '{4, 2, 0, 0, 25, 15, 1};
    vecs[5] = '{10, 2, 0, 0, 10, 10, 0};
`endif
    vecs[4] = '{50, 25, 0, 0, 2, 2, 0};
    vecs[6] = '{20, 5, 5, 1, 6, 6, 0};
    vecs[7] = '{30, 10, 10, 0, 3, 3, 0};
    vecs[8] = '{0, 0, 0, 0, 0, 0, 0};
    vecs[9] = '{10, 5, 0, 0, 10, 10, 0};

    repeat (3) tick();
    check("reset_count", freq_count, 0);
    check("reset_valid", freq_valid, 0);
    check("reset_overflow", overflow, 0);
    check("reset_stalled", stalled, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Main table: window k collects edges from its predecessor's LATCH cycle onward
    n0 = cyc;
    enable = 1'b1;
    for (int n = n0; n <= n0 + WIN * NV; n++) begin
      exp_v = (n > n0) && (((n - n0) % WIN) == 0);
      check("freq_valid", freq_valid, int'(exp_v));
      if (exp_v) begin
        w = (n - n0) / WIN - 1;
        check("win_count", freq_count, vecs[w].exp_cnt);
        check("win_overflow", overflow, 0);
        check("nar_valid", nar_valid, 1);
        check("nar_count", nar_count, vecs[w].exp_nar);
        check("nar_overflow", nar_ovf, vecs[w].exp_ovf);
        $display("window %0d: count=%0d narrow=%0d narrow_ovf=%0d", w, freq_count, nar_count, nar_ovf);
      end
      lvl = 1'b0;
      d = n - (n0 + WIN - L);
      if (d >= 0) begin
        k = d / WIN + 1;
        i = d % WIN;
        if (k < NV) lvl = pat(vecs[k], i);
        if (k - 1 < NV && vecs[k-1].tail != 0 && i < vecs[k-1].width - 1) lvl = 1'b1;
      end
      tach_in = lvl;
      tick();
    end

    // Abort at gate_cnt 60: outputs hold and no strobe for the discarded window
    tach_in = 1'b0;
    vend = n0 + WIN * NV;
    while (cyc < vend + 61) tick();
    enable = 1'b0;
    repeat (40) begin
      tick();
      check("abort_valid", freq_valid, 0);
      check("abort_hold_count", freq_count, vecs[NV-1].exp_cnt);
    end
    check("idle_stalled", stalled, 0);
    $display("abort: count held at %0d", freq_count);

    // Re-enable with three pulses, then a stall and a recovery pulse
    tick();
    m = cyc;
    enable = 1'b1;
    for (int j = 0; j <= 125; j++) begin
      check("reen_valid", freq_valid, int'(j == WIN));
      if (j == WIN) begin
        check("reen_count", freq_count, 3);
        check("reen_overflow", overflow, 0);
        $display("re-enable window: count=%0d", freq_count);
      end
      if (j == 50 + L + 49) check("stall_before", stalled, 0);
      if (j == 50 + L + 50) check("stall_set", stalled, 1);
      if (j == 115 + L) check("stall_hold_at_edge", stalled, 1);
      if (j == 116 + L) check("stall_clear", stalled, 0);
      tach_in = (j >= 10 && j < 15) || (j >= 30 && j < 35) || (j >= 50 && j < 55) || (j >= 115 && j < 120);
      tick();
    end
    $display("stall sequence done at cycle %0d (m=%0d)", cyc, m);

    // Asynchronous reset mid-window clears outputs without waiting for a clock
    repeat (4) tick();
    check("pre_reset_count", freq_count, 3);
    #1 rst_n = 1'b0;
    #1;
    check("rst_count", freq_count, 0);
    check("rst_valid", freq_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_stalled", stalled, 0);
    check("rst_nar_count", nar_count, 0);
    check("rst_nar_stalled", nar_stalled, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    r0 = cyc;
    for (int j = 0; j <= WIN; j++) begin
      check("post_rst_valid", freq_valid, int'(j == WIN));
      if (j == WIN) check("post_rst_count", freq_count, 0);
      tick();
    end
    $display("reset recovery: first valid after %0d cycles from cycle %0d", WIN, r0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
